// File: rtl/video_pll_cfg_pkg.sv
// Shared definitions for the video PLL reconfiguration controller.
//   pll_state_e  : controller FSM states
//   mode_entry_t : one divider set (input, feedback, four output dividers)
//   MODE_TABLE   : divider sets selectable through req_mode
package video_pll_cfg_pkg;

  localparam int DYN_W    = 10;
  localparam int MODE_W   = 2;
  localparam int MODE_CNT = 4;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_RST,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_ERROR
  } pll_state_e;

  typedef struct packed {
    logic [DYN_W-1:0]      idiv;
    logic [DYN_W-1:0]      fdiv;
    logic [3:0][DYN_W-1:0] odiv;
  } mode_entry_t;

  // odiv concatenations are written highest index first: {odiv3, odiv2, odiv1, odiv0}
  localparam mode_entry_t MODE_TABLE [MODE_CNT] = '{
    '{idiv: 10'd2, fdiv: 10'd32, odiv: {10'd100, 10'd100, 10'd100, 10'd100}},
    '{idiv: 10'd2, fdiv: 10'd32, odiv: {10'd200, 10'd200, 10'd200, 10'd200}},
    '{idiv: 10'd1, fdiv: 10'd30, odiv: {10'd4,   10'd20,  10'd2,   10'd10}},
    '{idiv: 10'd1, fdiv: 10'd29, odiv: {10'd6,   10'd24,  10'd3,   10'd12}}
  };

endpackage

// File: rtl/video_pll_reconfig_ctrl_if.sv
// Mode-change request handshake.
//   req_valid : requester has a mode change pending
//   req_mode  : requested mode index
//   req_ready : controller accepts when req_valid && req_ready
interface video_pll_reconfig_ctrl_if;

  logic                                  req_valid;
  logic [video_pll_cfg_pkg::MODE_W-1:0]  req_mode;
  logic                                  req_ready;

  modport master (output req_valid, output req_mode, input  req_ready);
  modport slave  (input  req_valid, input  req_mode, output req_ready);

endinterface

// File: rtl/video_pll_lock_sync.sv
// Brings the asynchronous PLL lock into clk and qualifies it.
//   pll_lock : raw lock from the PLL (asynchronous)
//   filt_en  : filter counts only while high; cleared otherwise
//   lock_s   : 2-flop synchronized lock
//   lock_ok  : this cycle is the LOCK_FILTER-th consecutive high sample
module video_pll_lock_sync #(
  parameter int LOCK_FILTER = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic filt_en,
  output logic lock_s,
  output logic lock_ok
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);

  logic [1:0]        sync_q;
  logic [FILT_W-1:0] filt_cnt;

  assign lock_s  = sync_q[1];
  assign lock_ok = filt_en && lock_s && (filt_cnt == FILT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      filt_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
      if (!filt_en || !lock_s) filt_cnt <= '0;
      else                     filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

endmodule

// File: rtl/video_pll_reconfig_ctrl.sv
// Video PLL reconfiguration controller: loads a divider set, pulses the PLL
// reset, waits for a filtered lock with timeout/retry, and watches for loss.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   req_if         : mode-change request handshake (slave side)
//   pll_lock       : raw PLL lock (asynchronous)
//   pll_rst        : PLL reset, active-high
//   dyn_*          : divider and duty settings for the PLL
//   locked, err    : filtered lock status, configuration failure
//   cur_mode       : mode currently loaded
//   lock_loss_cnt  : saturating count of lock losses
//
// state      | meaning
// LOAD       | one cycle, dyn_* take the table entry for cur_mode
// RST        | pll_rst held high for RST_CYCLES cycles
// WAIT_LOCK  | waiting for LOCK_FILTER consecutive lock samples, with timeout
// LOCKED     | lock established, requests accepted, loss monitored
// ERROR      | retries exhausted, requests accepted
module video_pll_reconfig_ctrl
  import video_pll_cfg_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 8,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  video_pll_reconfig_ctrl_if.slave  req_if,
  input  logic                      pll_lock,
  output logic                      pll_rst,
  output logic [DYN_W-1:0]          dyn_idiv,
  output logic [DYN_W-1:0]          dyn_fdiv,
  output logic [DYN_W-1:0]          dyn_odiv0,
  output logic [DYN_W-1:0]          dyn_odiv1,
  output logic [DYN_W-1:0]          dyn_odiv2,
  output logic [DYN_W-1:0]          dyn_odiv3,
  output logic [DYN_W-1:0]          dyn_duty0,
  output logic [DYN_W-1:0]          dyn_duty1,
  output logic [DYN_W-1:0]          dyn_duty2,
  output logic [DYN_W-1:0]          dyn_duty3,
  output logic                      locked,
  output logic                      err,
  output logic [MODE_W-1:0]         cur_mode,
  output logic [7:0]                lock_loss_cnt
);

  localparam int RST_W   = $clog2(RST_CYCLES);
  localparam int TMO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  pll_state_e         state, state_nx;
  logic               lock_s, lock_ok;
  logic               accept, timeout, lock_lost;
  logic               req_ready_q;
  logic [RST_W-1:0]   rst_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [RETRY_W-1:0] retry_cnt, retry_inc;
  mode_entry_t        entry;

  assign req_if.req_ready = req_ready_q;
  assign accept    = req_if.req_valid && req_ready_q;
  assign timeout   = (state == ST_WAIT_LOCK) && (tmo_cnt == TMO_LAST);
  assign lock_lost = (state == ST_LOCKED) && !lock_s;
  assign retry_inc = retry_cnt + RETRY_W'(1);
  assign entry     = MODE_TABLE[cur_mode];

  video_pll_lock_sync #(.LOCK_FILTER(LOCK_FILTER)) u_lock_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .filt_en  (state == ST_WAIT_LOCK),
    .lock_s   (lock_s),
    .lock_ok  (lock_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:      state_nx = ST_RST;
      ST_RST:       if (rst_cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        // a lock qualified on the last timeout cycle still counts as a lock
        if (lock_ok)      state_nx = ST_LOCKED;
        else if (timeout) state_nx = (retry_inc < RETRY_MAX) ? ST_RST : ST_ERROR;
      end
      ST_LOCKED: begin
        if (accept)       state_nx = ST_LOAD;
        else if (!lock_s) state_nx = ST_RST;
      end
      ST_ERROR:     if (accept) state_nx = ST_LOAD;
      default:      state_nx = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt       <= '0;
      tmo_cnt       <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      cur_mode      <= '0;
      pll_rst       <= 1'b1;
      locked        <= 1'b0;
      err           <= 1'b0;
      req_ready_q   <= 1'b0;
      dyn_idiv      <= MODE_TABLE[0].idiv;
      dyn_fdiv      <= MODE_TABLE[0].fdiv;
      dyn_odiv0     <= MODE_TABLE[0].odiv[0];
      dyn_odiv1     <= MODE_TABLE[0].odiv[1];
      dyn_odiv2     <= MODE_TABLE[0].odiv[2];
      dyn_odiv3     <= MODE_TABLE[0].odiv[3];
      dyn_duty0     <= MODE_TABLE[0].odiv[0];
      dyn_duty1     <= MODE_TABLE[0].odiv[1];
      dyn_duty2     <= MODE_TABLE[0].odiv[2];
      dyn_duty3     <= MODE_TABLE[0].odiv[3];
    end else begin
      // both timers restart whenever their state is entered
      rst_cnt <= (state == ST_RST && state_nx == ST_RST) ? rst_cnt + RST_W'(1) : '0;
      tmo_cnt <= (state == ST_WAIT_LOCK && state_nx == ST_WAIT_LOCK) ? tmo_cnt + TMO_W'(1) : '0;

      if (accept || lock_lost)    retry_cnt <= '0;
      else if (timeout && !lock_ok) retry_cnt <= retry_inc;

      // loss is counted even when a coincident request takes priority
      if (lock_lost && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;

      if (accept) cur_mode <= req_if.req_mode;

      if (state == ST_LOAD) begin
        dyn_idiv  <= entry.idiv;
        dyn_fdiv  <= entry.fdiv;
        dyn_odiv0 <= entry.odiv[0];
        dyn_odiv1 <= entry.odiv[1];
        dyn_odiv2 <= entry.odiv[2];
        dyn_odiv3 <= entry.odiv[3];
        dyn_duty0 <= entry.odiv[0];
        dyn_duty1 <= entry.odiv[1];
        dyn_duty2 <= entry.odiv[2];
        dyn_duty3 <= entry.odiv[3];
      end

      // status outputs are registered from the next state so they align with it
      pll_rst     <= (state_nx == ST_RST);
      locked      <= (state_nx == ST_LOCKED);
      err         <= (state_nx == ST_ERROR);
      req_ready_q <= (state_nx == ST_LOCKED) || (state_nx == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_video_pll_reconfig_ctrl.sv
// Self-checking bench for video_pll_reconfig_ctrl: mode table vectors plus
// hand-written sequences for reset, timeout/retry, lock loss and glitches.
module tb_video_pll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_rst, locked, err;
  logic [9:0] dyn_idiv, dyn_fdiv;
  logic [9:0] dyn_odiv0, dyn_odiv1, dyn_odiv2, dyn_odiv3;
  logic [9:0] dyn_duty0, dyn_duty1, dyn_duty2, dyn_duty3;
  logic [1:0] cur_mode;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  video_pll_reconfig_ctrl_if req_if ();

  video_pll_reconfig_ctrl #(
    .RST_CYCLES(16), .LOCK_FILTER(8), .LOCK_TIMEOUT(100), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_if(req_if), .pll_lock(pll_lock),
    .pll_rst(pll_rst),
    .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv),
    .dyn_odiv0(dyn_odiv0), .dyn_odiv1(dyn_odiv1), .dyn_odiv2(dyn_odiv2), .dyn_odiv3(dyn_odiv3),
    .dyn_duty0(dyn_duty0), .dyn_duty1(dyn_duty1), .dyn_duty2(dyn_duty2), .dyn_duty3(dyn_duty3),
    .locked(locked), .err(err), .cur_mode(cur_mode), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0] mode;
    int idiv, fdiv, od0, od1, od2, od3;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_dyn(input string tag, input vec_t v);
    check({tag, " idiv"},  dyn_idiv,  v.idiv);
    check({tag, " fdiv"},  dyn_fdiv,  v.fdiv);
    check({tag, " odiv0"}, dyn_odiv0, v.od0);
    check({tag, " odiv1"}, dyn_odiv1, v.od1);
    check({tag, " odiv2"}, dyn_odiv2, v.od2);
    check({tag, " odiv3"}, dyn_odiv3, v.od3);
    check({tag, " duty0"}, dyn_duty0, v.od0);
    check({tag, " duty3"}, dyn_duty3, v.od3);
  endtask

  // waits (bounded) for pll_rst to rise, then measures how long it stays high
  task automatic rst_pulse(input string name, input int exp_len);
    int w = 0;
    int n = 0;
    while (!pll_rst && w < 20) begin tick(); w++; end
    while (pll_rst && n < 200) begin tick(); n++; end
    check(name, n, exp_len);
  endtask

  task automatic wait_locked(input string name, input int budget);
    int n = 0;
    while (!locked && n < budget) begin tick(); n++; end
    check(name, locked, 1);
  endtask

  task automatic do_req(input string name, input logic [1:0] m);
    check({name, " ready before"}, req_if.req_ready, 1);
    req_if.req_valid = 1'b1;
    req_if.req_mode  = m;
    tick();
    req_if.req_valid = 1'b0;
    check({name, " ready after"}, req_if.req_ready, 0);
    check({name, " cur_mode"}, cur_mode, m);
  endtask

  initial begin
    int n, bad, pulses, hi_seen;
    logic prev;

    vecs[0] = '{2'd1, 2, 32, 200, 200, 200, 200};
    vecs[1] = '{2'd2, 1, 30, 10, 2, 20, 4};
    vecs[2] = '{2'd3, 1, 29, 12, 3, 24, 6};
    vecs[3] = '{2'd0, 2, 32, 100, 100, 100, 100};
    vecs[4] = '{2'd2, 1, 30, 10, 2, 20, 4};

    req_if.req_valid = 1'b0;
    req_if.req_mode  = 2'd0;

    // reset values
    repeat (3) tick();
    check("rst pll_rst", pll_rst, 1);
    check("rst locked", locked, 0);
    check("rst err", err, 0);
    check("rst req_ready", req_if.req_ready, 0);
    check("rst cur_mode", cur_mode, 0);
    check("rst loss_cnt", lock_loss_cnt, 0);
    check_dyn("rst", vecs[3]);

    // automatic mode-0 bring-up, lock rises 30 cycles after release
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && n < 100) begin n++; tick(); end
    check("boot pll_rst len", n, 16);
    repeat (30 - n) tick();
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 100) begin tick(); n++; end
    check("boot lock latency", n, 10);
    check("boot cur_mode", cur_mode, 0);
    check("boot odiv0", dyn_odiv0, 100);
    check("boot pll_rst", pll_rst, 0);

    // mode table vectors
    for (int i = 0; i < 5; i++) begin
      do_req($sformatf("vec%0d req", i), vecs[i].mode);
      rst_pulse($sformatf("vec%0d pulse", i), 16);
      wait_locked($sformatf("vec%0d relock", i), 60);
      check_dyn($sformatf("vec%0d", i), vecs[i]);
    end

    // single one-cycle lock drop
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 0;
    while (locked && n < 10) begin tick(); n++; end
    check("drop locked cleared", locked, 0);
    check("drop loss_cnt", lock_loss_cnt, 1);
    rst_pulse("drop pulse", 16);
    wait_locked("drop relock", 60);
    check("drop cur_mode", cur_mode, 2);
    check_dyn("drop", vecs[1]);

    // 300 more drops saturate the counter
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      n = 0;
      while (locked && n < 10) begin tick(); n++; end
      if (locked) bad++;
      n = 0;
      while (!locked && n < 60) begin tick(); n++; end
      if (!locked) bad++;
    end
    check("sat relock misses", bad, 0);
    check("sat loss_cnt", lock_loss_cnt, 255);

    // lock never comes: three attempts then ERROR
    pll_lock = 1'b0;
    do_req("tmo req", 2'd3);
    pulses = 0;
    prev = pll_rst;
    n = 0;
    while (!err && n < 600) begin
      tick();
      n++;
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
    end
    check("tmo pulses", pulses, 3);
    check("tmo err", err, 1);
    check("tmo ready", req_if.req_ready, 1);
    check("tmo locked", locked, 0);
    check("tmo pll_rst", pll_rst, 0);
    pll_lock = 1'b1;
    do_req("err req", 2'd0);
    check("err cleared", err, 0);
    rst_pulse("err pulse", 16);
    wait_locked("err relock", 60);
    check_dyn("err", vecs[3]);

    // short lock glitch in WAIT_LOCK, and a request there is ignored
    pll_lock = 1'b0;
    do_req("gl req", 2'd1);
    rst_pulse("gl pulse", 16);
    hi_seen = 0;
    pll_lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 2'd3;
        check("gl ready in wait", req_if.req_ready, 0);
      end
      tick();
      req_if.req_valid = 1'b0;
      if (locked) hi_seen++;
    end
    pll_lock = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (locked) hi_seen++;
    end
    check("gl locked seen", hi_seen, 0);
    check("gl cur_mode", cur_mode, 1);
    pll_lock = 1'b1;
    wait_locked("gl relock", 40);
    check("gl cur_mode after", cur_mode, 1);
    check_dyn("gl", vecs[0]);

    // reset asserted while locked aborts at once
    rst_n = 1'b0;
    #1;
    check("mid rst pll_rst", pll_rst, 1);
    check("mid rst locked", locked, 0);
    check("mid rst cur_mode", cur_mode, 0);
    check("mid rst loss_cnt", lock_loss_cnt, 0);
    check("mid rst odiv0", dyn_odiv0, 100);
    tick();
    tick();
    rst_n = 1'b1;
    rst_pulse("mid rst pulse", 16);
    wait_locked("mid rst relock", 60);

    // request in the same cycle lock loss is seen
    pll_lock = 1'b0;
    tick();
    tick();
    do_req("coin req", 2'd3);
    pll_lock = 1'b1;
    check("coin loss_cnt", lock_loss_cnt, 1);
    check("coin locked", locked, 0);
    rst_pulse("coin pulse", 16);
    wait_locked("coin relock", 60);
    check_dyn("coin", vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
